// File: rtl/dipswitch_ctrl.sv
`timescale 1ns/1ps
// Debounces eight 8-bit DIP switch banks into a committed 64-bit image with a sticky change interrupt.
// A raw change held steady is committed 3+DEBOUNCE_CYCLES rising edges later; RD is a combinational read.
module dipswitch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:2]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ,
  input  logic [7:0]  dip_switch0,
  input  logic [7:0]  dip_switch1,
  input  logic [7:0]  dip_switch2,
  input  logic [7:0]  dip_switch3,
  input  logic [7:0]  dip_switch4,
  input  logic [7:0]  dip_switch5,
  input  logic [7:0]  dip_switch6,
  input  logic [7:0]  dip_switch7
);

  typedef enum logic {ST_IDLE = 1'b0, ST_COUNT = 1'b1} state_t;

  localparam logic [19:0] LP_CNT_LAST     = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]  LP_ADDR_STAB_LO = 3'd0;
  localparam logic [2:0]  LP_ADDR_STAB_HI = 3'd1;
  localparam logic [2:0]  LP_ADDR_CTRL    = 3'd2;

  logic [63:0] w_raw;
  logic [63:0] r_sync1;
  logic [63:0] r_sync2;
  logic [63:0] r_candidate;
  logic [63:0] r_stable;
  logic [19:0] r_cnt;
  state_t      r_state;
  logic        r_ien;
  logic        r_pending;
  logic        w_ctrl_wr;
  logic        w_commit;
  logic        w_unused_wd;

  assign w_raw = {dip_switch7, dip_switch6, dip_switch5, dip_switch4,
                  dip_switch3, dip_switch2, dip_switch1, dip_switch0};

  assign w_ctrl_wr   = WE && (Addr == LP_ADDR_CTRL);
  assign w_commit    = (r_state == ST_COUNT) && (r_sync2 != r_stable) &&
                       (r_sync2 == r_candidate) && (r_cnt >= LP_CNT_LAST);
  assign w_unused_wd = &{1'b0, WD[31:2]};

  // Switch levels are asynchronous; only r_sync2 is safe to compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_candidate <= '0;
      r_stable    <= '0;
      r_cnt       <= '0;
      r_ien       <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_sync2 != r_stable) begin
            r_candidate <= r_sync2;
            r_cnt       <= '0;
            r_state     <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (r_sync2 == r_stable) begin
            r_state <= ST_IDLE;
          end else if (r_sync2 != r_candidate) begin
            r_candidate <= r_sync2;
            r_cnt       <= '0;
          end else if (r_cnt < LP_CNT_LAST) begin
            r_cnt <= r_cnt + 20'd1;
          end else begin
            r_stable <= r_candidate;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_ctrl_wr) begin
        r_ien <= WD[0];
      end
      // A commit on the same edge as a software clear keeps the event visible.
      if (w_commit) begin
        r_pending <= 1'b1;
      end else if (w_ctrl_wr && WD[1]) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    RD = '0;
    if (!reset) begin
      case (Addr)
        LP_ADDR_STAB_LO: RD = r_stable[31:0];
        LP_ADDR_STAB_HI: RD = r_stable[63:32];
        LP_ADDR_CTRL:    RD = {30'b0, r_pending, r_ien};
        default:         RD = '0;
      endcase
    end
  end

  assign IRQ = r_ien & r_pending;

endmodule

// File: tb/tb_dipswitch_ctrl.sv
`timescale 1ns/1ps
// Bench for dipswitch_ctrl: directed scenarios plus random switch/write/reset traffic,
// checked through an expectation queue against a run-length reference model.
module tb_dipswitch_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;
  logic [7:0]  dips [8];

  dipswitch_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .WD(WD), .RD(RD), .IRQ(IRQ),
    .dip_switch0(dips[0]), .dip_switch1(dips[1]), .dip_switch2(dips[2]), .dip_switch3(dips[3]),
    .dip_switch4(dips[4]), .dip_switch5(dips[5]), .dip_switch6(dips[6]), .dip_switch7(dips[7])
  );

  always #5 clk = ~clk;

  // Reference model: the synchronizer is a two-sample delay; a value is committed once
  // it has been seen on D+1 consecutive samples while differing from the committed image.
  logic [63:0] m_p1, m_p2, m_stable, m_run_val;
  int          m_run_len;
  logic        m_ien, m_pending;

  always @(posedge clk) begin
    logic [63:0] s;
    logic        commit;
    s = m_p2;
    if (reset) begin
      m_p1 = '0; m_p2 = '0; m_stable = '0; m_run_val = '0; m_run_len = 0;
      m_ien = 1'b0; m_pending = 1'b0;
    end else begin
      if (m_run_len != 0 && s == m_run_val) m_run_len = m_run_len + 1;
      else begin
        m_run_val = s;
        m_run_len = 1;
      end
      commit = (s != m_stable) && (m_run_len == DEB + 1);
      if (commit) m_stable = s;
      if (WE && Addr == 3'd2) m_ien = WD[0];
      if (commit) m_pending = 1'b1;
      else if (WE && Addr == 3'd2 && WD[1]) m_pending = 1'b0;
      m_p2 = m_p1;
      m_p1 = {dips[7], dips[6], dips[5], dips[4], dips[3], dips[2], dips[1], dips[0]};
    end
  end

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    if (reset) return 32'd0;
    case (a)
      3'd0:    return m_stable[31:0];
      3'd1:    return m_stable[63:32];
      3'd2:    return {30'b0, m_pending, m_ien};
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard: stimulus queues the expected response, the monitor pops on each sample strobe.
  string       name_q [$];
  logic [31:0] rd_q   [$];
  logic        irq_q  [$];
  logic        smp_tick = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(posedge smp_tick) begin
    string       nm;
    logic [31:0] erd;
    logic        eirq;
    n_tests = n_tests + 1;
    if (name_q.size() == 0) begin
      n_fail = n_fail + 1;
      $display("FAIL monitor: sample with no queued expectation (RD=%h IRQ=%b)", RD, IRQ);
    end else begin
      nm   = name_q.pop_front();
      erd  = rd_q.pop_front();
      eirq = irq_q.pop_front();
      if (RD !== erd || IRQ !== eirq) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got RD=%h IRQ=%b, expected RD=%h IRQ=%b", nm, RD, IRQ, erd, eirq);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input logic [2:0] a, input logic [31:0] erd, input logic eirq,
                        input string nm);
    Addr = a;
    WE   = 1'b0;
    name_q.push_back(nm);
    rd_q.push_back(erd);
    irq_q.push_back(eirq);
    #1 smp_tick = 1'b1;
    #1 smp_tick = 1'b0;
  endtask

  task automatic chk(input logic [2:0] a, input string nm);
    sample(a, m_rd(a), m_ien & m_pending, nm);
  endtask

  task automatic chkc(input logic [2:0] a, input logic [31:0] erd, input logic eirq,
                      input string nm);
    sample(a, erd, eirq, nm);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    Addr = a;
    WE   = 1'b1;
    WD   = d;
    step(1);
    WE   = 1'b0;
    WD   = '0;
  endtask

  initial begin
    int          r;
    logic [2:0]  wa;
    reset = 1'b1; WE = 1'b0; Addr = '0; WD = '0;
    for (int i = 0; i < 8; i++) dips[i] = 8'h00;

    step(2);
    chkc(3'd0, 32'h0, 1'b0, "rst_rd_lo");
    chkc(3'd2, 32'h0, 1'b0, "rst_ctrl");

    // Commit latency: nothing before edge 7, A5 after it.
    reset = 1'b0;
    dips[0] = 8'hA5;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      chkc(3'd0, 32'h0, 1'b0, $sformatf("hold_e%0d", e));
    end
    step(1);
    chkc(3'd0, 32'h000000A5, 1'b0, "commit_e7");
    chkc(3'd2, 32'h2, 1'b0, "pending_set");

    // Interrupt enable, commit-driven IRQ, and software clear.
    wr(3'd2, 32'h1);
    chkc(3'd2, 32'h3, 1'b1, "irq_on_ien");
    wr(3'd2, 32'h3);
    chkc(3'd2, 32'h1, 1'b0, "pend_clear");
    dips[1] = 8'h3C;
    step(6);
    chkc(3'd0, 32'h000000A5, 1'b0, "irq_pre_commit");
    step(1);
    chkc(3'd0, 32'h00003CA5, 1'b1, "irq_commit");
    wr(3'd2, 32'h3);
    chkc(3'd2, 32'h1, 1'b0, "irq_clear");

    // Commit coincides with a clear: set wins.
    dips[2] = 8'h77;
    step(6);
    wr(3'd2, 32'h3);
    chkc(3'd2, 32'h3, 1'b1, "set_wins");
    chkc(3'd0, 32'h00773CA5, 1'b1, "set_wins_data");
    wr(3'd2, 32'h3);

    // Two-cycle glitch is rejected.
    dips[7] = 8'h01;
    step(2);
    dips[7] = 8'h00;
    step(8);
    chkc(3'd1, 32'h0, 1'b0, "glitch_hi");
    chkc(3'd2, 32'h1, 1'b0, "glitch_pend");

    // Candidate changes at cnt=2: counter restarts, only 0F is committed.
    dips[3] = 8'hFF;
    step(3);
    dips[3] = 8'h0F;
    for (int e = 4; e <= 12; e++) begin
      step(1);
      chkc(3'd0, (e >= 10) ? 32'h0F773CA5 : 32'h00773CA5, (e >= 10), $sformatf("restart_e%0d", e));
    end
    chkc(3'd2, 32'h3, 1'b1, "restart_pend");
    wr(3'd2, 32'h3);

    // Reset mid-COUNT aborts the change, then live switches recommit.
    dips[4] = 8'h55;
    step(4);
    reset = 1'b1;
    chkc(3'd0, 32'h0, 1'b0, "rd_in_reset");
    step(2);
    chkc(3'd2, 32'h0, 1'b0, "ctrl_in_reset");
    reset = 1'b0;
    step(1);
    chkc(3'd0, 32'h0, 1'b0, "abort_lo");
    chkc(3'd1, 32'h0, 1'b0, "abort_hi");
    chkc(3'd2, 32'h0, 1'b0, "abort_ctrl");
    step(5);
    chkc(3'd0, 32'h0, 1'b0, "recommit_e6");
    step(1);
    chkc(3'd0, 32'h0F773CA5, 1'b0, "recommit_lo");
    chkc(3'd1, 32'h00000055, 1'b0, "recommit_hi");
    chkc(3'd2, 32'h2, 1'b0, "recommit_pend");

    // Random traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 99);
      reset = (r == 99);
      if (r < 12) dips[$urandom_range(0, 7)] = 8'($urandom);
      chk(3'($urandom_range(0, 7)), "rand_rd");
      chk(3'd2, "rand_ctrl");
      if (r >= 12 && r < 20) begin
        wa = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
        wr(wa, $urandom);
      end else begin
        step(1);
      end
    end
    reset = 1'b0;
    step(1);
    chk(3'd0, "final_lo");
    chk(3'd1, "final_hi");
    chk(3'd2, "final_ctrl");

    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
